ntt_seq_ctrl: RTL and testbench

Sequencing controller for the Kyber 256-point NTT/INTT datapath. It owns the coefficient-RAM address ports, butterfly enables and twiddle index, and walks one polynomial through three phases: load (two coefficients per accepted beat), compute (7 butterfly layers, plus a scaling pass for inverse), and unload (two coefficients per beat). It sits between the host-side load/unload handshake and the coefficient RAM plus butterfly datapath, which are instantiated by the wrapper.

---
 rtl/ntt_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl
// Sequencing controller for the Kyber 256-point NTT/INTT datapath.
// Walks one polynomial through load, compute and unload. It drives the
// coefficient-RAM address ports, the butterfly issue strobe and the twiddle
// index. Butterfly results are written back through a fixed-latency shift
// register that mirrors the butterfly pipeline depth.
module ntt_seq_ctrl #(
  parameter int BF_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       rd_en,
  output logic [7:0] rd_addr1,
  output logic [7:0] rd_addr2,
  output logic       wr_en,
  output logic [7:0] wr_addr1,
  output logic [7:0] wr_addr2,
  output logic       wr_src,
  output logic       bf_en,
  output logic [1:0] bf_op,
  output logic [6:0] zeta_idx,
  output logic [2:0] layer,
  output logic       in_done,
  output logic       cal_done,
  output logic       done,
  output logic       busy
);

  // Last GAP count value; the gap lasts exactly BF_LAT cycles.
  localparam logic [3:0] GAP_LAST = 4'(BF_LAT - 1);

  localparam logic [1:0] OP_CT    = 2'd1;
  localparam logic [1:0] OP_GS    = 2'd2;
  localparam logic [1:0] OP_SCALE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_GAP,
    S_OUT
  } state_t;

  state_t     state_reg;
  logic       mode_reg;      // 1 = inverse transform
  logic [6:0] beat_reg;      // load beat index k
  logic [6:0] j_reg;         // butterfly index within the current layer
  logic [2:0] layer_reg;     // current layer 0..7
  logic [3:0] gap_reg;       // idle cycles spent in GAP
  logic [7:0] pair_reg;      // unload pairs issued; bit 7 set when all issued
  logic       in_done_reg;
  logic       cal_done_reg;
  logic       done_reg;
  logic       out_valid_reg;

  // Write-back delay line, one entry per butterfly pipeline stage.
  logic [BF_LAT-1:0]      wb_valid_reg;
  logic [BF_LAT-1:0][7:0] wb_addr1_reg;
  logic [BF_LAT-1:0][7:0] wb_addr2_reg;

  logic       load_beat;
  logic       calc_issue;
  logic       out_issue;
  logic       last_layer;

  // Butterfly address decode intermediates.
  logic [3:0] shamt;
  logic [7:0] j_ext;
  logic [7:0] span;
  logic [7:0] grp;
  logic [7:0] ofs;
  logic [7:0] bf_addr1;
  logic [7:0] bf_addr2;
  logic [7:0] zeta_sum;
  logic [1:0] op_sel;

  // Handshake qualifiers and the final-layer test derived from the state registers.
  always_comb begin
    load_beat  = (state_reg == S_LOAD) && in_valid;
    calc_issue = (state_reg == S_CALC);
    out_issue  = (state_reg == S_OUT) && out_ready && !pair_reg[7];
    last_layer = mode_reg ? (layer_reg == 3'd7) : (layer_reg == 3'd6);
  end

  // Butterfly addressing: a layer pairs coefficients 'span' apart, so
  // address1 is j with a zero bit inserted at the span position. The
  // inverse scale pass walks plain adjacent pairs.
  always_comb begin
    j_ext    = {1'b0, j_reg};
    shamt    = 4'd0;
    span     = 8'd0;
    grp      = 8'd0;
    ofs      = 8'd0;
    bf_addr1 = 8'd0;
    bf_addr2 = 8'd0;
    zeta_sum = 8'd0;
    op_sel   = 2'd0;
    if (mode_reg && (layer_reg == 3'd7)) begin
      bf_addr1 = {j_reg, 1'b0};
      bf_addr2 = {j_reg, 1'b1};
      op_sel   = OP_SCALE;
    end else begin
      // Forward spans shrink 128..2, inverse spans grow 2..128.
      if (mode_reg) begin
        shamt = {1'b0, layer_reg} + 4'd1;
      end else begin
        shamt = 4'd7 - {1'b0, layer_reg};
      end
      span     = 8'd1 << shamt;
      grp      = j_ext >> shamt;
      ofs      = j_ext & (span - 8'd1);
      bf_addr1 = (grp << (shamt + 4'd1)) | ofs;
      bf_addr2 = bf_addr1 + span;
      if (mode_reg) begin
        // Inverse consumes twiddles from the top of the table downward.
        zeta_sum = (8'd128 >> layer_reg) - 8'd1 - grp;
        op_sel   = OP_GS;
      end else begin
        zeta_sum = (8'd1 << layer_reg) + grp;
        op_sel   = OP_CT;
      end
    end
  end

  // Read port and butterfly issue: compute reads in CALC, unload reads in OUT.
  always_comb begin
    rd_en    = 1'b0;
    bf_en    = 1'b0;
    rd_addr1 = 8'd0;
    rd_addr2 = 8'd0;
    bf_op    = 2'd0;
    zeta_idx = 7'd0;
    if (calc_issue) begin
      rd_en    = 1'b1;
      bf_en    = 1'b1;
      rd_addr1 = bf_addr1;
      rd_addr2 = bf_addr2;
      bf_op    = op_sel;
      zeta_idx = zeta_sum[6:0];
    end else if (out_issue) begin
      rd_en    = 1'b1;
      rd_addr1 = {pair_reg[6:0], 1'b0};
      rd_addr2 = {pair_reg[6:0], 1'b1};
    end
  end

  // Write port: host load beats, otherwise the delayed butterfly results.
  // The delay line is empty whenever LOAD is active, so they never collide.
  always_comb begin
    wr_en    = 1'b0;
    wr_src   = 1'b0;
    wr_addr1 = 8'd0;
    wr_addr2 = 8'd0;
    if (load_beat) begin
      wr_en    = 1'b1;
      wr_addr1 = {beat_reg, 1'b0};
      wr_addr2 = {beat_reg, 1'b1};
    end else if (wb_valid_reg[BF_LAT-1]) begin
      wr_en    = 1'b1;
      wr_src   = 1'b1;
      wr_addr1 = wb_addr1_reg[BF_LAT-1];
      wr_addr2 = wb_addr2_reg[BF_LAT-1];
    end
  end

  // Write-back delay line; it drains regardless of state, and reset flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg <= '0;
      wb_addr1_reg <= '0;
      wb_addr2_reg <= '0;
    end else begin
      wb_valid_reg[0] <= calc_issue;
      wb_addr1_reg[0] <= rd_addr1;
      wb_addr2_reg[0] <= rd_addr2;
      for (int i = 1; i < BF_LAT; i++) begin
        wb_valid_reg[i] <= wb_valid_reg[i-1];
        wb_addr1_reg[i] <= wb_addr1_reg[i-1];
        wb_addr2_reg[i] <= wb_addr2_reg[i-1];
      end
    end
  end

  // Phase sequencer with registered completion pulses and unload valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      mode_reg      <= 1'b0;
      beat_reg      <= 7'd0;
      j_reg         <= 7'd0;
      layer_reg     <= 3'd0;
      gap_reg       <= 4'd0;
      pair_reg      <= 8'd0;
      in_done_reg   <= 1'b0;
      cal_done_reg  <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      in_done_reg   <= 1'b0;
      cal_done_reg  <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= out_issue;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            mode_reg  <= mode;
            beat_reg  <= 7'd0;
            layer_reg <= 3'd0;
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            beat_reg <= beat_reg + 7'd1;
            if (beat_reg == 7'd127) begin
              in_done_reg <= 1'b1;
              j_reg       <= 7'd0;
              layer_reg   <= 3'd0;
              state_reg   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          j_reg <= j_reg + 7'd1;
          if (j_reg == 7'd127) begin
            gap_reg   <= 4'd0;
            state_reg <= S_GAP;
          end
        end
        S_GAP: begin
          // Hold off the next layer until every pending write has landed.
          if (gap_reg == GAP_LAST) begin
            if (last_layer) begin
              cal_done_reg <= 1'b1;
              pair_reg     <= 8'd0;
              state_reg    <= S_OUT;
            end else begin
              layer_reg <= layer_reg + 3'd1;
              j_reg     <= 7'd0;
              state_reg <= S_CALC;
            end
          end else begin
            gap_reg <= gap_reg + 4'd1;
          end
        end
        S_OUT: begin
          if (out_issue) begin
            pair_reg <= pair_reg + 8'd1;
            // done lines up with the out_valid of the final pair.
            if (pair_reg == 8'd127) begin
              done_reg <= 1'b1;
            end
          end else if (pair_reg[7]) begin
            layer_reg <= 3'd0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy      = (state_reg != S_IDLE);
    in_ready  = (state_reg == S_LOAD);
    layer     = layer_reg;
    in_done   = in_done_reg;
    cal_done  = cal_done_reg;
    done      = done_reg;
    out_valid = out_valid_reg;
  end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl
// Randomized bench for ntt_seq_ctrl. A monitor logs every issue, write and
// pulse; each job is then compared against a reference schedule computed
// from the layer/group/offset arithmetic of the transform.
module tb_ntt_seq_ctrl;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic       rd_en;
  logic [7:0] rd_addr1;
  logic [7:0] rd_addr2;
  logic       wr_en;
  logic [7:0] wr_addr1;
  logic [7:0] wr_addr2;
  logic       wr_src;
  logic       bf_en;
  logic [1:0] bf_op;
  logic [6:0] zeta_idx;
  logic [2:0] layer;
  logic       in_done;
  logic       cal_done;
  logic       done;
  logic       busy;

  ntt_seq_ctrl #(.BF_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_src(wr_src),
    .bf_en(bf_en), .bf_op(bf_op), .zeta_idx(zeta_idx), .layer(layer),
    .in_done(in_done), .cal_done(cal_done), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int cyc;
    int a1;
    int a2;
    int z;
    int op;
    int l;
  } ev_t;

  ev_t iss_q[$];
  ev_t wb_q[$];
  ev_t oiss_q[$];
  int  ov_q[$];
  int  ld_q[$];
  int  cov[256];
  int  ld_cnt, ld_order_err, bad_ld, stall_iss, mon_err, overlap;
  int  n_ind, n_cal, n_done, ind_cyc, cal_cyc, done_cyc;
  bit  done_seen;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_mon();
    iss_q.delete(); wb_q.delete(); oiss_q.delete(); ov_q.delete(); ld_q.delete();
    foreach (cov[i]) cov[i] = 0;
    ld_cnt = 0; ld_order_err = 0; bad_ld = 0; stall_iss = 0; mon_err = 0; overlap = 0;
    n_ind = 0; n_cal = 0; n_done = 0; ind_cyc = -1; cal_cyc = -1; done_cyc = -1;
    done_seen = 1'b0;
  endtask

  // Monitor: log one sample per cycle, away from the active edge.
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst) begin
      e.cyc = cycle; e.a1 = int'(rd_addr1); e.a2 = int'(rd_addr2);
      e.z = int'(zeta_idx); e.op = int'(bf_op); e.l = int'(layer);
      if (bf_en) begin
        iss_q.push_back(e);
        if (!rd_en) mon_err++;
      end
      if (rd_en && !bf_en) begin
        oiss_q.push_back(e);
        if (!out_ready) stall_iss++;
      end
      if (wr_en && wr_src) begin
        e.a1 = int'(wr_addr1); e.a2 = int'(wr_addr2);
        wb_q.push_back(e);
      end
      if (wr_en && !wr_src) begin
        ld_q.push_back(cycle);
        if (!(in_valid && in_ready)) bad_ld++;
        if (int'(wr_addr1) != 2 * ld_cnt || int'(wr_addr2) != 2 * ld_cnt + 1) ld_order_err++;
        cov[wr_addr1] = cov[wr_addr1] + 1;
        cov[wr_addr2] = cov[wr_addr2] + 1;
        ld_cnt++;
      end
      if (out_valid) ov_q.push_back(cycle);
      if (in_done)  begin n_ind++;  ind_cyc  = cycle; end
      if (cal_done) begin n_cal++;  cal_cyc  = cycle; end
      if (done)     begin n_done++; done_cyc = cycle; done_seen = 1'b1; end
      if (int'(in_done) + int'(cal_done) + int'(done) > 1) overlap++;
    end
  end

  function automatic int fpack(int l, int op, int z, int a1, int a2);
    return (((l * 4 + op) * 128 + z) * 256 + a1) * 256 + a2;
  endfunction

  // Reference butterfly schedule for layer l, butterfly j.
  function automatic int exp_issue(bit m, int l, int j);
    int len, g, o, a1, a2, z, op;
    if (!m) begin
      len = 128 >> l; g = j / len; o = j % len;
      a1 = 2 * g * len + o; a2 = a1 + len; z = (1 << l) + g; op = 1;
    end else if (l < 7) begin
      len = 2 << l; g = j / len; o = j % len;
      a1 = 2 * g * len + o; a2 = a1 + len; z = (128 >> l) - 1 - g; op = 2;
    end else begin
      a1 = 2 * j; a2 = 2 * j + 1; z = 0; op = 3;
    end
    return fpack(l, op, z, a1, a2);
  endfunction

  task automatic spot(input string nm, input int idx, input int a1, input int a2,
                      input int z, input int op);
    if (idx < iss_q.size()) begin
      check({nm, ".addr_op"}, (iss_q[idx].a1 * 256 + iss_q[idx].a2) * 4 + iss_q[idx].op,
            (a1 * 256 + a2) * 4 + op);
      if (z >= 0) check({nm, ".zeta"}, iss_q[idx].z, z);
    end else begin
      check({nm, ".present"}, iss_q.size(), idx + 1);
    end
  endtask

  task automatic run_job(input bit m, input int in_pat, input int out_pat, input bit poke);
    int  n, stall_left;
    bit  stalled, poked;
    clear_mon();
    @(posedge clk); #1;
    mode = m; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    n = 0; stall_left = 0; stalled = 1'b0; poked = 1'b0;
    while (!done_seen && n < 6000) begin
      case (in_pat)
        0:       in_valid = 1'b1;
        1:       in_valid = (n % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      case (out_pat)
        0: out_ready = 1'b1;
        1: begin
          if (!stalled && oiss_q.size() == 40) begin stalled = 1'b1; stall_left = 10; end
          if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
          else out_ready = 1'b1;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && !poked && iss_q.size() == 300) begin start = 1'b1; poked = 1'b1; end
      else start = 1'b0;
      if (in_pat == 2) mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_job(input string nm, input bit m, input bit in_held, input int out_pat);
    int nl, n, haz, err, t0, cnt;
    int last_wr[256];
    nl = m ? 8 : 7;
    n  = nl * 128;
    check({nm, ".done_seen"}, int'(done_seen), 1);
    check({nm, ".busy_after"}, int'(busy), 0);
    // load phase
    check({nm, ".ld_n"}, ld_cnt, 128);
    check({nm, ".ld_order"}, ld_order_err, 0);
    check({nm, ".ld_hs"}, bad_ld, 0);
    cnt = 0;
    foreach (cov[i]) if (cov[i] == 1) cnt++;
    check({nm, ".ld_cover"}, cnt, 256);
    if (ld_q.size() > 0) check({nm, ".in_done_t"}, ind_cyc, ld_q[ld_q.size()-1] + 1);
    if (in_held && ld_q.size() == 128) check({nm, ".ld_span"}, ld_q[127] - ld_q[0], 127);
    // compute phase against the reference schedule
    check({nm, ".iss_n"}, iss_q.size(), n);
    check({nm, ".rd_with_bf"}, mon_err, 0);
    t0 = (iss_q.size() > 0) ? iss_q[0].cyc : 0;
    for (int i = 0; i < n && i < iss_q.size(); i++) begin
      check({nm, ".iss_t"}, iss_q[i].cyc - t0, (i / 128) * (128 + L) + i % 128);
      check({nm, ".iss_f"}, fpack(iss_q[i].l, iss_q[i].op, iss_q[i].z, iss_q[i].a1, iss_q[i].a2),
            exp_issue(m, i / 128, i % 128));
    end
    check({nm, ".span"}, cal_cyc - t0, nl * (128 + L));
    // write-back mirrors the issue stream L cycles later
    check({nm, ".wb_n"}, wb_q.size(), n);
    for (int i = 0; i < wb_q.size() && i < iss_q.size(); i++) begin
      check({nm, ".wb_t"}, wb_q[i].cyc, iss_q[i].cyc + L);
      check({nm, ".wb_a"}, wb_q[i].a1 * 256 + wb_q[i].a2, iss_q[i].a1 * 256 + iss_q[i].a2);
    end
    // no read may see an address whose write is still in flight
    foreach (last_wr[i]) last_wr[i] = -100000;
    haz = 0;
    foreach (iss_q[i]) begin
      if (last_wr[iss_q[i].a1] >= iss_q[i].cyc || last_wr[iss_q[i].a2] >= iss_q[i].cyc) haz++;
      last_wr[iss_q[i].a1] = iss_q[i].cyc + L;
      last_wr[iss_q[i].a2] = iss_q[i].cyc + L;
    end
    foreach (oiss_q[i])
      if (last_wr[oiss_q[i].a1] >= oiss_q[i].cyc || last_wr[oiss_q[i].a2] >= oiss_q[i].cyc) haz++;
    check({nm, ".hazard"}, haz, 0);
    // unload phase
    check({nm, ".out_n"}, oiss_q.size(), 128);
    err = 0;
    foreach (oiss_q[i]) if (oiss_q[i].a1 != 2 * i || oiss_q[i].a2 != 2 * i + 1) err++;
    check({nm, ".out_addr"}, err, 0);
    check({nm, ".out_stall"}, stall_iss, 0);
    check({nm, ".ov_n"}, ov_q.size(), 128);
    err = 0;
    for (int i = 0; i < ov_q.size() && i < oiss_q.size(); i++)
      if (ov_q[i] != oiss_q[i].cyc + 1) err++;
    check({nm, ".ov_t"}, err, 0);
    if (ov_q.size() > 0) check({nm, ".done_t"}, done_cyc, ov_q[ov_q.size()-1]);
    if (out_pat == 0 && oiss_q.size() == 128) check({nm, ".out_span"}, oiss_q[127].cyc - oiss_q[0].cyc, 127);
    if (out_pat == 1 && oiss_q.size() > 40) check({nm, ".stall_gap"}, oiss_q[40].cyc - oiss_q[39].cyc, 11);
    // completion pulses
    check({nm, ".n_in_done"}, n_ind, 1);
    check({nm, ".n_cal_done"}, n_cal, 1);
    check({nm, ".n_done"}, n_done, 1);
    check({nm, ".overlap"}, overlap, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.rd", int'({rd_en, rd_addr1, rd_addr2, bf_en, bf_op, zeta_idx}), 0);
    check("reset.wr", int'({wr_en, wr_addr1, wr_addr2, wr_src}), 0);
    check("reset.ctl", int'({in_ready, out_valid, layer, in_done, cal_done, done, busy}), 0);
    #1 rst = 1'b0;

    // forward, streams held ready, start poked mid-compute
    run_job(1'b0, 0, 0, 1'b1);
    $display("job fwd: issues=%0d writes=%0d outs=%0d", iss_q.size(), wb_q.size(), oiss_q.size());
    check_job("fwd", 1'b0, 1'b1, 0);
    spot("fwd.l0j0",   0,   0, 128,  1, 1);
    spot("fwd.l0j127", 127, 127, 255, 1, 1);
    spot("fwd.l6j0",   768, 0, 2,   64, 1);
    spot("fwd.l6j1",   769, 1, 3,   64, 1);
    spot("fwd.l6j2",   770, 4, 6,   65, 1);

    // inverse, streams held ready
    run_job(1'b1, 0, 0, 1'b0);
    $display("job inv: issues=%0d writes=%0d outs=%0d", iss_q.size(), wb_q.size(), oiss_q.size());
    check_job("inv", 1'b1, 1'b1, 0);
    spot("inv.l0j0", 0,   0, 2,   127, 2);
    spot("inv.l6j0", 768, 0, 128, -1,  2);
    spot("inv.l7j5", 901, 10, 11, 0,   3);

    // forward with in_valid toggling and a 10-cycle out_ready stall
    run_job(1'b0, 1, 1, 1'b0);
    $display("job bp: issues=%0d writes=%0d outs=%0d", iss_q.size(), wb_q.size(), oiss_q.size());
    check_job("bp", 1'b0, 1'b0, 1);

    // inverse with random handshakes
    run_job(1'b1, 2, 2, 1'b0);
    $display("job rnd: issues=%0d writes=%0d outs=%0d", iss_q.size(), wb_q.size(), oiss_q.size());
    check_job("rnd", 1'b1, 1'b0, 2);

    // reset at layer 3, j=50
    clear_mon();
    @(posedge clk); #1;
    mode = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (iss_q.size() < 3 * 128 + 51 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rst.reach", iss_q.size(), 3 * 128 + 51);
    check("rst.layer", int'(layer), 3);
    #1 rst = 1'b1;
    @(negedge clk);
    $display("job rst: reset applied after %0d issues", iss_q.size());
    check("rst.rd", int'({rd_en, rd_addr1, rd_addr2, bf_en, bf_op, zeta_idx}), 0);
    check("rst.wr", int'({wr_en, wr_addr1, wr_addr2, wr_src}), 0);
    check("rst.ctl", int'({in_ready, out_valid, layer, in_done, cal_done, done}), 0);
    check("rst.busy", int'(busy), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // clean job after the abort
    run_job(1'b0, 2, 2, 1'b0);
    $display("job post: issues=%0d writes=%0d outs=%0d", iss_q.size(), wb_q.size(), oiss_q.size());
    check_job("post", 1'b0, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
